// File: rtl/alu_resp_tx.sv
// -----------------------------------------------------------------------------
// alu_resp_tx
//
// Response framer for the UART ALU path. It takes one completed ALU result
// per request and sends it out as a byte stream to the UART transmitter:
//
//   opcode, 0x00, len[7:0], len[15:8], result byte 0 .. result byte N-1
//
// len is the total packet length in bytes, header included.
//
// Optional build macro:
//   ALU_RESP_CHECKSUM_EN - adds one trailing byte that is the XOR of every
//                          earlier byte in the packet, and counts that byte
//                          in len.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   req_valid_i    result request valid
//   req_ready_o    high only while idle; request accepted on valid & ready
//   req_opcode_i   opcode echoed as the first byte
//   req_result_i   result word, RESULT_BYTES*8 bits, sent LSB first
//   m_axis_tdata   byte to the UART transmitter (registered)
//   m_axis_tvalid  byte valid (registered)
//   m_axis_tready  UART transmitter ready
//   busy_o         high from request accept until the last byte handshake
//
// Handshake rule on both interfaces: a transfer happens on a rising edge
// where valid and ready are both high. Once m_axis_tvalid is raised, it and
// m_axis_tdata are held unchanged until that transfer happens.
// -----------------------------------------------------------------------------
module alu_resp_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int RESULT_BYTES = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [7:0]                req_opcode_i,
    input  logic [RESULT_BYTES*8-1:0] req_result_i,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      busy_o
);

    localparam int CNT_W = $clog2(RESULT_BYTES + 1);

`ifdef ALU_RESP_CHECKSUM_EN
    localparam logic [15:0] PKT_LEN = 16'(5 + RESULT_BYTES);
`else
    localparam logic [15:0] PKT_LEN = 16'(4 + RESULT_BYTES);
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_OPCODE  = 3'd1,
        S_RSVD    = 3'd2,
        S_LEN_LO  = 3'd3,
        S_LEN_HI  = 3'd4,
`ifdef ALU_RESP_CHECKSUM_EN
        S_PAYLOAD = 3'd5,
        S_CSUM    = 3'd6
`else
        S_PAYLOAD = 3'd5
`endif
    } state_e;

    state_e                    state_q, state_d;
    logic [RESULT_BYTES*8-1:0] result_q, result_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]     tdata_q, tdata_d;
    logic                      tvalid_q, tvalid_d;
    logic                      busy_q, busy_d;
    logic                      hs;
`ifdef ALU_RESP_CHECKSUM_EN
    logic [7:0]                csum_q, csum_d;
`endif

    // Select payload byte k of the latched result.
    function automatic logic [7:0] pick_byte(input logic [RESULT_BYTES*8-1:0] w,
                                             input logic [CNT_W-1:0]          k);
        pick_byte = 8'h00;
        for (int i = 0; i < RESULT_BYTES; i++) begin
            if (k == CNT_W'(i)) pick_byte = w[8*i +: 8];
        end
    endfunction

    assign hs = tvalid_q && m_axis_tready;

    // The opcode needs no separate holding register: it is loaded straight
    // into tdata_q on accept and is only ever sent from there.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        busy_d   = busy_q;
`ifdef ALU_RESP_CHECKSUM_EN
        csum_d   = csum_q;
        if (hs) csum_d = csum_q ^ tdata_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    state_d  = S_OPCODE;
                    result_d = req_result_i;
                    cnt_d    = '0;
                    tdata_d  = req_opcode_i;
                    tvalid_d = 1'b1;
                    busy_d   = 1'b1;
`ifdef ALU_RESP_CHECKSUM_EN
                    csum_d   = 8'h00;
`endif
                end
            end
            S_OPCODE: if (hs) begin
                state_d = S_RSVD;
                tdata_d = 8'h00;
            end
            S_RSVD: if (hs) begin
                state_d = S_LEN_LO;
                tdata_d = PKT_LEN[7:0];
            end
            S_LEN_LO: if (hs) begin
                state_d = S_LEN_HI;
                tdata_d = PKT_LEN[15:8];
            end
            S_LEN_HI: if (hs) begin
                state_d = S_PAYLOAD;
                cnt_d   = '0;
                tdata_d = pick_byte(result_q, '0);
            end
            S_PAYLOAD: if (hs) begin
                if (cnt_q == CNT_W'(RESULT_BYTES - 1)) begin
`ifdef ALU_RESP_CHECKSUM_EN
                    // The byte being handed over now still has to be
                    // folded in, since csum_q only updates at this edge.
                    state_d  = S_CSUM;
                    tdata_d  = csum_q ^ tdata_q;
`else
                    state_d  = S_IDLE;
                    tdata_d  = 8'h00;
                    tvalid_d = 1'b0;
                    busy_d   = 1'b0;
`endif
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    tdata_d = pick_byte(result_q, cnt_q + CNT_W'(1));
                end
            end
`ifdef ALU_RESP_CHECKSUM_EN
            S_CSUM: if (hs) begin
                state_d  = S_IDLE;
                tdata_d  = 8'h00;
                tvalid_d = 1'b0;
                busy_d   = 1'b0;
            end
`endif
            default: begin
                state_d  = S_IDLE;
                tdata_d  = 8'h00;
                tvalid_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            cnt_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            busy_q   <= 1'b0;
`ifdef ALU_RESP_CHECKSUM_EN
            csum_q   <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            busy_q   <= busy_d;
`ifdef ALU_RESP_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    assign req_ready_o   = (state_q == S_IDLE);
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_alu_resp_tx.sv
// -----------------------------------------------------------------------------
// tb_alu_resp_tx
//
// Bench for alu_resp_tx (RESULT_BYTES = 4).
//
// The reference model is a packet-level byte list. Each accepted request
// appends its whole expected byte sequence to exp_q. The model then predicts
// the interface at every falling edge:
//   - idle / ready / busy follow from whether exp_q is empty;
//   - every output handshake must pop the next expected byte;
//   - a stalled byte must reappear unchanged at the next falling edge.
//
// Define ALU_RESP_CHECKSUM_EN for this bench as well as the DUT.
// -----------------------------------------------------------------------------
module tb_alu_resp_tx;

    localparam int RB = 4;
`ifdef ALU_RESP_CHECKSUM_EN
    localparam int PKT_N = 5 + RB;
`else
    localparam int PKT_N = 4 + RB;
`endif
    localparam int TMO = 3000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [7:0]    req_opcode;
    logic [RB*8-1:0] req_result;
    logic [7:0]    tdata;
    logic          tvalid;
    logic          tready;
    logic          busy;

    int            n_checks = 0;
    int            n_pass   = 0;
    int            n_fail   = 0;
    logic [7:0]    exp_q[$];
    int            ready_mode = 0;   // 0 directed, 1 pattern 1,0,0, 2 random
    int            phase = 0;
    logic          stall = 1'b0;
    logic [7:0]    stall_data = 8'h00;

    alu_resp_tx #(.DATA_WIDTH(8), .RESULT_BYTES(RB)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_opcode_i (req_opcode),
        .req_result_i (req_result),
        .m_axis_tdata (tdata),
        .m_axis_tvalid(tvalid),
        .m_axis_tready(tready),
        .busy_o       (busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Byte k of the packet for a request, straight from the framing rules.
    function automatic logic [7:0] pkt_byte(input logic [7:0] op, input logic [RB*8-1:0] res,
                                            input int k);
        logic [15:0] len;
        logic [7:0]  x;
        len = 16'(PKT_N);
        if (k == 0) return op;
        if (k == 1) return 8'h00;
        if (k == 2) return len[7:0];
        if (k == 3) return len[15:8];
        if (k < 4 + RB) return 8'((res >> (8 * (k - 4))) & 'hFF);
        x = 8'h00;
        for (int j = 0; j < k; j++) x = x ^ pkt_byte(op, res, j);
        return x;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            stall = 1'b0;
        end else begin
            logic idle_m;
            logic [7:0] e;
            idle_m = (exp_q.size() == 0);
            check("req_ready", req_ready, idle_m);
            check("busy", busy, !idle_m);
            check("tvalid", tvalid, !idle_m);
            if (stall) check("hold_tdata", tdata, stall_data);
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    check("extra_byte", tdata, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("byte", tdata, e);
                end
                stall = 1'b0;
            end else if (tvalid) begin
                stall      = 1'b1;
                stall_data = tdata;
            end else begin
                stall = 1'b0;
            end
            if (idle_m && req_valid) begin
                for (int k = 0; k < PKT_N; k++) exp_q.push_back(pkt_byte(req_opcode, req_result, k));
            end
        end
    end

    // ---------------- tready driver ----------------
    always @(posedge clk) begin
        #1;
        if (ready_mode == 1) begin
            tready = (phase == 0);
            phase  = (phase + 1) % 3;
        end else if (ready_mode == 2) begin
            tready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the accept edge.
    task automatic send_req(input logic [7:0] op, input logic [RB*8-1:0] res);
        int cyc;
        req_valid  = 1'b1;
        req_opcode = op;
        req_result = res;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!req_ready && cyc < TMO);
        if (cyc >= TMO) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            #1;
            cyc++;
        end while ((exp_q.size() != 0 || !req_ready) && cyc < TMO);
        if (cyc >= TMO) check("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_opcode = 8'h00;
        req_result = '0;
        tready     = 1'b1;
        #3;
        check("rst_tvalid", tvalid, 0);
        check("rst_tdata", tdata, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: one byte per cycle with tready high, then idle the next cycle.
        send_req(8'h02, 32'h1234_5678);
        for (int k = 0; k < PKT_N; k++) begin
            @(negedge clk);
            check("t1_tvalid", tvalid, 1);
            check("t1_tdata", tdata, pkt_byte(8'h02, 32'h1234_5678, k));
        end
        @(negedge clk);
        check("t1_busy_after", busy, 0);
        check("t1_ready_after", req_ready, 1);
        @(posedge clk);
        #1;

        // 2: same request under a 1,0,0 tready pattern.
        ready_mode = 1;
        send_req(8'h02, 32'h1234_5678);
        wait_idle();

        // 3: inputs change on the edge after accept; second request waits.
        send_req(8'h02, 32'h1234_5678);
        send_req(8'h03, 32'hFFFF_FFFF);
        wait_idle();

        // 4: back-to-back requests with tready high.
        ready_mode = 0;
        tready     = 1'b1;
        send_req(8'h04, 32'h0000_0001);
        send_req(8'h01, 32'hA5A5_A5A5);
        wait_idle();

        // Random requests, gaps and backpressure.
        ready_mode = 2;
        for (int p = 0; p < 20; p++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send_req(8'($urandom_range(0, 255)), $urandom);
        end
        wait_idle();

        // 5: reset during LEN_HI while stalled, then a clean packet.
        ready_mode = 0;
        tready     = 1'b1;
        send_req(8'h02, 32'h1234_5678);
        repeat (3) @(posedge clk);
        #1 tready = 1'b0;
        @(negedge clk);
        check("t5_len_hi", tdata, pkt_byte(8'h02, 32'h1234_5678, 3));
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_tvalid", tvalid, 0);
        check("t5_async_busy", busy, 0);
        check("t5_async_ready", req_ready, 1);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n  = 1'b1;
        tready = 1'b1;
        @(posedge clk);
        #1;
        send_req(8'h01, 32'h0000_BEEF);
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
